// File: rtl/audio_voice_alloc_pkg.sv
// Shared types for the polyphonic voice allocator: voice/FSM states and the latched event.
// SUSTAINED exists only when AUDIO_VOICE_ALLOC_SUSTAIN_EN is defined.
package audio_voice_alloc_pkg;

  // Event fields are sized for the widest supported note/velocity; narrower values are zero-extended.
  localparam int EVT_NOTE_W = 16;
  localparam int EVT_VEL_W  = 16;
  localparam int AGE_W_DEF  = 8;
  localparam int AGE_MAX    = (1 << AGE_W_DEF) - 1;

  typedef enum logic [1:0] {
    V_FREE      = 2'd0,
    V_HELD      = 2'd1,
    V_RELEASING = 2'd2
`ifdef AUDIO_VOICE_ALLOC_SUSTAIN_EN
    , V_SUSTAINED = 2'd3
`endif
  } voice_state_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_COMMIT = 2'd2
  } alloc_fsm_t;

  typedef struct packed {
    logic                  on;
    logic [EVT_NOTE_W-1:0] note;
    logic [EVT_VEL_W-1:0]  vel;
  } evt_t;

endpackage

// File: rtl/audio_voice_select.sv
// Combinational voice picker: note-on picks same-note, free, oldest releasing, then oldest held;
// note-off picks the lowest held voice with the matching note.
module audio_voice_select
  import audio_voice_alloc_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int NOTE_W     = 7,
  parameter int AGE_W      = 8,
  parameter int IDX_W      = 3
) (
  input  voice_state_t                 i_state [NUM_VOICES],
  input  logic [NUM_VOICES*NOTE_W-1:0] i_note,
  input  logic [NUM_VOICES*AGE_W-1:0]  i_age,
  input  logic                         i_evt_on,
  input  logic [EVT_NOTE_W-1:0]        i_evt_note,
  output logic [IDX_W-1:0]             o_idx,
  output logic                         o_hit
);

  logic             w_match_hit, w_free_hit, w_rel_hit, w_held_hit;
  logic [IDX_W-1:0] w_match_idx, w_free_idx, w_rel_idx, w_held_idx;
  logic [AGE_W-1:0] w_rel_age, w_held_age;

  always_comb begin
    w_match_hit = 1'b0; w_match_idx = '0;
    w_free_hit  = 1'b0; w_free_idx  = '0;
    w_rel_hit   = 1'b0; w_rel_idx   = '0; w_rel_age  = '0;
    w_held_hit  = 1'b0; w_held_idx  = '0; w_held_age = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      // Strict '>' on age keeps the lowest index among equally old voices.
      if (!w_match_hit && (EVT_NOTE_W'(i_note[i*NOTE_W +: NOTE_W]) == i_evt_note) &&
          (i_evt_on ? (i_state[i] != V_FREE) : (i_state[i] == V_HELD))) begin
        w_match_hit = 1'b1;
        w_match_idx = IDX_W'(i);
      end
      if (!w_free_hit && i_state[i] == V_FREE) begin
        w_free_hit = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (i_state[i] == V_RELEASING && (!w_rel_hit || i_age[i*AGE_W +: AGE_W] > w_rel_age)) begin
        w_rel_hit = 1'b1;
        w_rel_idx = IDX_W'(i);
        w_rel_age = i_age[i*AGE_W +: AGE_W];
      end
      if ((i_state[i] == V_HELD
`ifdef AUDIO_VOICE_ALLOC_SUSTAIN_EN
           || i_state[i] == V_SUSTAINED
`endif
          ) && (!w_held_hit || i_age[i*AGE_W +: AGE_W] > w_held_age)) begin
        w_held_hit = 1'b1;
        w_held_idx = IDX_W'(i);
        w_held_age = i_age[i*AGE_W +: AGE_W];
      end
    end
  end

  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    if (!i_evt_on) begin
      o_hit = w_match_hit;
      o_idx = w_match_idx;
    end else if (w_match_hit) begin
      o_hit = 1'b1; o_idx = w_match_idx;
    end else if (w_free_hit) begin
      o_hit = 1'b1; o_idx = w_free_idx;
    end else if (w_rel_hit) begin
      o_hit = 1'b1; o_idx = w_rel_idx;
    end else if (w_held_hit) begin
      o_hit = 1'b1; o_idx = w_held_idx;
    end
  end

endmodule

// File: rtl/audio_voice_allocator.sv
// Polyphony scheduler: accepts note events (IDLE->SEARCH->COMMIT) and drives per-voice gate/note/vel/trig.
// Optional sustain pedal support is enabled with `define AUDIO_VOICE_ALLOC_SUSTAIN_EN.
module audio_voice_allocator
  import audio_voice_alloc_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int NOTE_W     = 7,
  parameter int VEL_W      = 7,
  parameter int AGE_W      = AGE_W_DEF
) (
  input  logic                                ACLK,
  input  logic                                ARESETN,
  input  logic                                evt_valid,
  output logic                                evt_ready,
  input  logic                                evt_on,
  input  logic [NOTE_W-1:0]                   evt_note,
  input  logic [VEL_W-1:0]                    evt_vel,
  input  logic [NUM_VOICES-1:0]               voice_release_done,
`ifdef AUDIO_VOICE_ALLOC_SUSTAIN_EN
  input  logic                                sustain,
`endif
  output logic [NUM_VOICES-1:0]               voice_gate,
  output logic [NUM_VOICES-1:0]               voice_trig,
  output logic [NUM_VOICES*NOTE_W-1:0]        voice_note,
  output logic [NUM_VOICES*VEL_W-1:0]         voice_vel,
  output logic [$clog2(NUM_VOICES+1)-1:0]     active_count
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int CNT_W = $clog2(NUM_VOICES + 1);

  alloc_fsm_t                   r_fsm, w_fsm_nxt;
  logic                         r_run, w_accept, w_search, w_commit;
  evt_t                         r_evt;
  logic [IDX_W-1:0]             r_sel_idx, w_sel_idx;
  logic                         r_sel_hit, w_sel_hit;
  voice_state_t                 r_vstate [NUM_VOICES];
  voice_state_t                 w_vstate_nxt [NUM_VOICES];
  logic [NUM_VOICES*NOTE_W-1:0] r_note, w_note_nxt;
  logic [NUM_VOICES*VEL_W-1:0]  r_vel, w_vel_nxt;
  logic [NUM_VOICES*AGE_W-1:0]  r_age, w_age_nxt;
  logic [NUM_VOICES-1:0]        r_trig, w_trig_nxt;
  logic [CNT_W-1:0]             r_active, w_active_nxt;

  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
    return (&a) ? a : a + AGE_W'(1);
  endfunction

`ifdef AUDIO_VOICE_ALLOC_SUSTAIN_EN
  logic r_sus_q;
  logic w_sus_fall;
  assign w_sus_fall = r_sus_q & ~sustain;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_sus_q <= 1'b0;
    else          r_sus_q <= sustain;
  end
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_fsm     <= S_IDLE;
      r_run     <= 1'b0;
      r_sel_hit <= 1'b0;
    end else begin
      r_fsm <= w_fsm_nxt;
      r_run <= 1'b1;
      if (w_search) r_sel_hit <= w_sel_hit;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    evt_ready = 1'b0;
    w_accept  = 1'b0;
    w_search  = 1'b0;
    w_commit  = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        evt_ready = r_run;
        if (evt_valid && r_run) begin
          w_accept  = 1'b1;
          w_fsm_nxt = S_SEARCH;
        end
      end
      S_SEARCH: begin
        w_search  = 1'b1;
        w_fsm_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        w_commit  = 1'b1;
        w_fsm_nxt = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  // Accept stage: latch event (zero velocity folds to note-off); search stage: latch the pick.
  always_ff @(posedge ACLK) begin
    if (w_accept) begin
      r_evt.on   <= evt_on && (evt_vel != '0);
      r_evt.note <= EVT_NOTE_W'(evt_note);
      r_evt.vel  <= EVT_VEL_W'(evt_vel);
    end
    if (w_search) r_sel_idx <= w_sel_idx;
  end

  audio_voice_select #(
    .NUM_VOICES (NUM_VOICES),
    .NOTE_W     (NOTE_W),
    .AGE_W      (AGE_W),
    .IDX_W      (IDX_W)
  ) u_select (
    .i_state    (r_vstate),
    .i_note     (r_note),
    .i_age      (r_age),
    .i_evt_on   (r_evt.on),
    .i_evt_note (r_evt.note),
    .o_idx      (w_sel_idx),
    .o_hit      (w_sel_hit)
  );

  // Commit stage: a commit to a voice overrides a same-cycle release-done on it.
  always_comb begin
    w_note_nxt   = r_note;
    w_vel_nxt    = r_vel;
    w_age_nxt    = r_age;
    w_trig_nxt   = '0;
    w_active_nxt = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_vstate_nxt[i] = r_vstate[i];
      if (w_commit && r_sel_hit && r_sel_idx == IDX_W'(i)) begin
        if (r_evt.on) begin
          w_vstate_nxt[i]                = V_HELD;
          w_note_nxt[i*NOTE_W +: NOTE_W] = NOTE_W'(r_evt.note);
          w_vel_nxt[i*VEL_W +: VEL_W]    = VEL_W'(r_evt.vel);
          w_age_nxt[i*AGE_W +: AGE_W]    = '0;
          w_trig_nxt[i]                  = 1'b1;
        end else begin
`ifdef AUDIO_VOICE_ALLOC_SUSTAIN_EN
          w_vstate_nxt[i] = sustain ? V_SUSTAINED : V_RELEASING;
`else
          w_vstate_nxt[i] = V_RELEASING;
`endif
        end
      end else if (voice_release_done[i] && r_vstate[i] == V_RELEASING) begin
        w_vstate_nxt[i]             = V_FREE;
        w_age_nxt[i*AGE_W +: AGE_W] = '0;
      end else begin
`ifdef AUDIO_VOICE_ALLOC_SUSTAIN_EN
        if (w_sus_fall && r_vstate[i] == V_SUSTAINED) w_vstate_nxt[i] = V_RELEASING;
`endif
        if (w_commit && r_evt.on && r_vstate[i] != V_FREE)
          w_age_nxt[i*AGE_W +: AGE_W] = age_sat_inc(r_age[i*AGE_W +: AGE_W]);
      end
      if (w_vstate_nxt[i] != V_FREE) w_active_nxt = w_active_nxt + CNT_W'(1);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_VOICES; i++) r_vstate[i] <= V_FREE;
      r_note   <= '0;
      r_vel    <= '0;
      r_age    <= '0;
      r_trig   <= '0;
      r_active <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) r_vstate[i] <= w_vstate_nxt[i];
      r_note   <= w_note_nxt;
      r_vel    <= w_vel_nxt;
      r_age    <= w_age_nxt;
      r_trig   <= w_trig_nxt;
      r_active <= w_active_nxt;
    end
  end

  always_comb begin
    voice_gate = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_gate[i] = (r_vstate[i] == V_HELD)
`ifdef AUDIO_VOICE_ALLOC_SUSTAIN_EN
                      || (r_vstate[i] == V_SUSTAINED)
`endif
                      ;
    end
  end

  assign voice_trig   = r_trig;
  assign voice_note   = r_note;
  assign voice_vel    = r_vel;
  assign active_count = r_active;

endmodule
